// File: rtl/mod_exp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_exp_pkg
// Description : Shared defaults and state encoding for the modular
//               exponentiation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_exp_pkg;

    localparam int C_WIDTH     = 32;
    localparam int C_EXP_WIDTH = 32;
    localparam int C_IDX_W     = 8;

    // Controller states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_SQR_REQ  = 3'd2,
        S_SQR_WAIT = 3'd3,
        S_MUL_REQ  = 3'd4,
        S_MUL_WAIT = 3'd5,
        S_FIN      = 3'd6
    } state_t;

endpackage : mod_exp_pkg
`default_nettype wire

// File: rtl/mod_exp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_exp_ctrl_if
// Description : Start/done handshake bus to the shared modular multiplier.
//               master = controller, slave = multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
import mod_exp_pkg::*;

interface mod_exp_ctrl_if #(
    parameter int WIDTH = C_WIDTH
) ();
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_n;
    logic             mm_done;
    logic [WIDTH-1:0] mm_res;

    modport master (
        output mm_start, mm_a, mm_b, mm_n,
        input  mm_done, mm_res
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_n,
        output mm_done, mm_res
    );
endinterface : mod_exp_ctrl_if
`default_nettype wire

// File: rtl/mod_exp_ctrl_msb_scan.sv
`default_nettype none
// ============================================================================
// Module      : msb_scan
// Description : Sequential exponent bit scanner. Holds the latched exponent
//               and a bit index that starts at the MSB and steps downward.
//               o_found = bit at current index, o_zero = index is 0.
// Revision    : 1.0 - initial release
// ============================================================================
import mod_exp_pkg::*;

module msb_scan #(
    parameter int EXP_WIDTH = C_EXP_WIDTH,
    parameter int IDX_W     = C_IDX_W
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_load,
    input  wire logic [EXP_WIDTH-1:0] i_exp,
    input  wire logic                 i_step,
    output logic                      o_found,
    output logic                      o_zero
);

    localparam logic [IDX_W-1:0] C_TOP = IDX_W'(EXP_WIDTH - 1);

    logic [EXP_WIDTH-1:0] r_exp;
    logic [IDX_W-1:0]     r_idx;
    logic [EXP_WIDTH-1:0] w_shifted;

    // Load exponent and reset index to MSB; step never wraps below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_exp <= i_exp;
            r_idx <= C_TOP;
        end else if (i_step && (r_idx != '0)) begin
            r_idx <= r_idx - IDX_W'(1);
        end
    end

    assign w_shifted = r_exp >> r_idx;
    assign o_found   = w_shifted[0];
    assign o_zero    = (r_idx == '0);

endmodule : msb_scan
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mod_exp_ctrl
// Description : Left-to-right square-and-multiply controller computing
//               base^exponent mod modulus by scheduling one operation at a
//               time on an external modular multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
import mod_exp_pkg::*;

module mod_exp_ctrl #(
    parameter int WIDTH     = C_WIDTH,
    parameter int EXP_WIDTH = C_EXP_WIDTH,
    parameter int IDX_W     = C_IDX_W
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start,
    input  wire logic [WIDTH-1:0]     base,
    input  wire logic [WIDTH-1:0]     modulus,
    input  wire logic [EXP_WIDTH-1:0] exponent,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [WIDTH-1:0]          result,
    mod_exp_ctrl_if.master            mm
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic             w_accept;
    logic             w_scan_step;
    logic             w_acc_we;
    logic             w_result_we;
    logic [WIDTH-1:0] w_result_d;
    logic             w_found;
    logic             w_zero;
    logic             w_mul_phase;

    msb_scan #(
        .EXP_WIDTH (EXP_WIDTH),
        .IDX_W     (IDX_W)
    ) u_msb_scan (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_exp   (exponent),
        .i_step  (w_scan_step),
        .o_found (w_found),
        .o_zero  (w_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and control strobes; result is written on the edge into FIN
    // so it is already valid in the cycle done is high
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_scan_step = 1'b0;
        w_acc_we    = 1'b0;
        w_result_we = 1'b0;
        w_result_d  = r_result;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (modulus == '0) begin
                        w_result_we = 1'b1;
                        w_result_d  = '0;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (w_found) begin
                    w_state_nxt = S_SQR_REQ;
                end else if (!w_zero) begin
                    w_scan_step = 1'b1;
                end else begin
                    // exponent is zero: x^0 mod N is 1, except mod 1
                    w_result_we = 1'b1;
                    w_result_d  = (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
                    w_state_nxt = S_FIN;
                end
            end
            S_SQR_REQ: w_state_nxt = S_SQR_WAIT;
            S_SQR_WAIT: begin
                if (mm.mm_done) begin
                    w_acc_we = 1'b1;
                    if (w_found) begin
                        w_state_nxt = S_MUL_REQ;
                    end else if (w_zero) begin
                        w_result_we = 1'b1;
                        w_result_d  = mm.mm_res;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_scan_step = 1'b1;
                        w_state_nxt = S_SQR_REQ;
                    end
                end
            end
            S_MUL_REQ: w_state_nxt = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mm.mm_done) begin
                    w_acc_we = 1'b1;
                    if (w_zero) begin
                        w_result_we = 1'b1;
                        w_result_d  = mm.mm_res;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_scan_step = 1'b1;
                        w_state_nxt = S_SQR_REQ;
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch and error flag, updated only on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_n    <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_base <= base;
            r_n    <= modulus;
            r_err  <= (modulus == '0);
        end
    end

    // Accumulator: 1 at start, multiplier result after each operation
    always_ff @(posedge clk) begin
        if (rst)           r_acc <= '0;
        else if (w_accept) r_acc <= WIDTH'(1);
        else if (w_acc_we) r_acc <= mm.mm_res;
    end

    // Result holding register
    always_ff @(posedge clk) begin
        if (rst)              r_result <= '0;
        else if (w_result_we) r_result <= w_result_d;
    end

    // Operands derive from registers that only change on mm_done, so they
    // stay stable for the whole outstanding operation
    assign w_mul_phase = (r_state == S_MUL_REQ) || (r_state == S_MUL_WAIT);
    assign mm.mm_start = (r_state == S_SQR_REQ) || (r_state == S_MUL_REQ);
    assign mm.mm_a     = r_acc;
    assign mm.mm_b     = w_mul_phase ? r_base : r_acc;
    assign mm.mm_n     = r_n;

    assign busy   = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done   = (r_state == S_FIN);
    assign err    = r_err;
    assign result = r_result;

endmodule : mod_exp_ctrl
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_exp_ctrl
// Description : Self-checking bench for mod_exp_ctrl with a stub modular
//               multiplier of configurable latency and an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
import mod_exp_pkg::*;

module tb_mod_exp_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  base;
    logic [W-1:0]  modulus;
    logic [W-1:0]  exponent;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  result;

    mod_exp_ctrl_if #(.WIDTH(W)) mm_if ();

    mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(32), .IDX_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .modulus  (modulus),
        .exponent (exponent),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .mm       (mm_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Reference: right-to-left binary exponentiation with 64-bit arithmetic
    function automatic logic [31:0] ref_modexp(input logic [31:0] b, e, n);
        logic [63:0] r, x;
        if (n == 0) return 32'd0;
        r = 64'(1) % 64'(n);
        x = 64'(b) % 64'(n);
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % 64'(n);
            x = (x * x) % 64'(n);
        end
        return r[31:0];
    endfunction

    // Expected multiplier operations: (msb+1) squares + popcount multiplies
    function automatic int ref_ops(input logic [31:0] n, e);
        int msb, pop;
        msb = 0; pop = 0;
        if (n == 0 || e == 0) return 0;
        for (int i = 0; i < 32; i++) if (e[i]) begin msb = i; pop++; end
        return msb + 1 + pop;
    endfunction

    // ---------------- stub multiplier + monitors (negedge) ----------------
    int          lat_lo = 1, lat_hi = 1;
    int          n_start = 0, done_cnt = 0, proto_err = 0;
    bit          ignore_chk = 1'b0;
    bit          pend = 1'b0;
    int          cnt;
    logic [31:0] ca, cb, cn;

    initial begin
        mm_if.mm_done = 1'b0;
        mm_if.mm_res  = '0;
    end

    always @(negedge clk) begin
        mm_if.mm_done = 1'b0;
        if (done) done_cnt++;
        if (pend) begin
            if (!ignore_chk && (mm_if.mm_start || mm_if.mm_a !== ca || mm_if.mm_b !== cb))
                proto_err++;
            cnt--;
            if (cnt == 0) begin
                mm_if.mm_done = 1'b1;
                mm_if.mm_res  = (cn == 0) ? 32'd0 : 32'((64'(ca) * 64'(cb)) % 64'(cn));
                pend = 1'b0;
            end
        end else if (mm_if.mm_start) begin
            n_start++;
            ca   = mm_if.mm_a;
            cb   = mm_if.mm_b;
            cn   = mm_if.mm_n;
            cnt  = $urandom_range(lat_hi, lat_lo);
            pend = 1'b1;
        end
    end

    // ---------------- transaction helpers ----------------
    task automatic run_op(input logic [31:0] b, n, e,
                          output logic [31:0] r, output logic er,
                          output bit to, output int cyc);
        @(negedge clk);
        base = b; modulus = n; exponent = e; start = 1'b1;
        n_start = 0; done_cnt = 0; proto_err = 0;
        @(negedge clk);
        start = 1'b0;
        to = 1'b1; cyc = 0;
        for (int k = 0; k < 5000; k++) begin
            if (done) begin to = 1'b0; cyc = k; break; end
            @(negedge clk);
        end
        r  = result;
        er = err;
    endtask

    task automatic do_case(input string nm, input logic [31:0] b, n, e,
                           input logic [31:0] xr, input logic xe, input int xmm);
        logic [31:0] r;
        logic        er;
        bit          to;
        int          cyc;
        run_op(b, n, e, r, er, to, cyc);
        check({nm, "_timeout"}, 64'(to), 64'd0);
        check({nm, "_result"}, 64'(r), 64'(xr));
        check({nm, "_err"}, 64'(er), 64'(xe));
        check({nm, "_mm_ops"}, 64'(n_start), 64'(xmm));
        if (e == 0 && n != 0) check({nm, "_scan_cycles"}, 64'(cyc), 64'd32);
        @(negedge clk);
        check({nm, "_done_once"}, 64'(done_cnt), 64'd1);
        check({nm, "_idle_after"}, 64'({busy, done}), 64'd0);
        check({nm, "_protocol"}, 64'(proto_err), 64'd0);
    endtask

    typedef struct {
        logic [31:0] b, n, e;
        int          lo, hi;
        logic [31:0] r;
        logic        er;
        int          mm;
        bit          use_model;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] b, n, e;
        logic [31:0] xr;
        bit          to;
        int          k;

        tbl[0] = '{32'd3, 32'd7,       32'd5,          4, 4,  32'd5,   1'b0, 5,  1'b0};
        tbl[1] = '{32'd4, 32'd497,     32'd13,         1, 10, 32'd445, 1'b0, 7,  1'b0};
        tbl[2] = '{32'd9, 32'd7,       32'd0,          1, 3,  32'd1,   1'b0, 0,  1'b0};
        tbl[3] = '{32'd9, 32'd1,       32'd0,          1, 3,  32'd0,   1'b0, 0,  1'b0};
        tbl[4] = '{32'd5, 32'd0,       32'd3,          1, 3,  32'd0,   1'b1, 0,  1'b0};
        tbl[5] = '{32'd2, 32'd1000003, 32'h8000_0000,  1, 5,  32'd0,   1'b0, 33, 1'b1};
        tbl[6] = '{32'd3, 32'd7,       32'd5,          1, 1,  32'd5,   1'b0, 5,  1'b0};

        rst = 1'b1; start = 1'b0; base = '0; modulus = '0; exponent = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_status", 64'({busy, done, err}), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_mm", 64'({mm_if.mm_start, mm_if.mm_a, mm_if.mm_b}), 64'd0);
        check("reset_mm_n", 64'(mm_if.mm_n), 64'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 7; i++) begin
            lat_lo = tbl[i].lo; lat_hi = tbl[i].hi;
            xr = tbl[i].use_model ? ref_modexp(tbl[i].b, tbl[i].e, tbl[i].n) : tbl[i].r;
            do_case($sformatf("vec%0d", i), tbl[i].b, tbl[i].n, tbl[i].e, xr, tbl[i].er, tbl[i].mm);
            if (tbl[i].er) begin
                repeat (5) @(negedge clk);
                check($sformatf("vec%0d_err_hold", i), 64'({err, result}), {31'd0, 1'b1, 32'd0});
            end
        end

        // ---- reset in the middle of an operation, late mm_done ----
        lat_lo = 4; lat_hi = 4;
        @(negedge clk);
        base = 32'd3; modulus = 32'd7; exponent = 32'd5; start = 1'b1; n_start = 0;
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        for (k = 0; k < 200; k++) begin
            if (n_start == 2) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("midrst_reach_2nd", 64'(to), 64'd0);
        ignore_chk = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        check("midrst_status", 64'({busy, done, err, mm_if.mm_start}), 64'd0);
        check("midrst_values", 64'({result, mm_if.mm_a}), 64'd0);
        check("midrst_values2", 64'({mm_if.mm_b, mm_if.mm_n}), 64'd0);
        repeat (10) @(negedge clk);
        ignore_chk = 1'b0;
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        check("midrst_quiet", 64'({busy, result}), 64'd0);
        check("midrst_no_more_ops", 64'(n_start), 64'd2);
        do_case("after_rst", 32'd3, 32'd7, 32'd5, 32'd5, 1'b0, 5);

        // ---- start re-pulsed while busy ----
        lat_lo = 4; lat_hi = 4;
        @(negedge clk);
        base = 32'd3; modulus = 32'd7; exponent = 32'd5; start = 1'b1;
        n_start = 0; done_cnt = 0; proto_err = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        base = 32'd4; modulus = 32'd497; exponent = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        for (k = 0; k < 500; k++) begin
            if (done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("busy_start_timeout", 64'(to), 64'd0);
        check("busy_start_result", 64'(result), 64'd5);
        check("busy_start_ops", 64'(n_start), 64'd5);
        @(negedge clk);
        check("busy_start_done_once", 64'(done_cnt), 64'd1);
        check("busy_start_protocol", 64'(proto_err), 64'd0);

        // ---- randomized operands against the reference model ----
        lat_lo = 1; lat_hi = 10;
        for (int i = 0; i < 15; i++) begin
            b = $urandom;
            n = (i % 3 == 0) ? 32'($urandom_range(1000, 2)) : ($urandom | 32'd1);
            e = (i % 5 == 0) ? 32'($urandom_range(255, 1)) : $urandom;
            do_case($sformatf("rnd%0d", i), b, n, e, ref_modexp(b, e, n), 1'b0, ref_ops(n, e));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mod_exp_ctrl
`default_nettype wire

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
Sequential controller that computes base^exponent mod modulus using left-to-right square-and-multiply. It owns no multiplier itself. It schedules a shared external modular multiplier (mm_*) through a start/done handshake, one operation at a time, and scans the exponent for its MSB before issuing any operation. It sits between the RSA top level (operands, start/done) and the modular-multiply/reduce datapath.

Parameters:
WIDTH, 32, width of base, modulus, result and multiplier operands
EXP_WIDTH, 32, width of exponent
IDX_W, 8, width of bit-index counter (must satisfy 2^IDX_W > EXP_WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
base  input  WIDTH  message/base, latched on accepted start
modulus  input  WIDTH  N, latched on accepted start
exponent  input  EXP_WIDTH  e, latched on accepted start
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse, result valid
err  output  1  set with done when modulus==0; held until next accepted start
result  output  WIDTH  final value, held until next accepted start
mm_start  output  1  one-cycle pulse launching one modular multiply
mm_a  output  WIDTH  multiplicand, stable from mm_start until mm_done
mm_b  output  WIDTH  multiplier, stable from mm_start until mm_done
mm_n  output  WIDTH  modulus (latched copy)
mm_done  input  1  one-cycle pulse from multiplier, any latency >=1
mm_res  input  WIDTH  (mm_a*mm_b) mod mm_n, valid when mm_done

Behaviour:
- One clock, clk. Reset is synchronous, active-high, named rst. Reset has priority over all other inputs.
- Reset values: busy=0, done=0, err=0, result=0, mm_start=0, mm_a=mm_b=mm_n=0, state=IDLE.
- States: IDLE, SCAN, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, FIN.
- IDLE, start=1: latch operands, set acc=1, idx=EXP_WIDTH-1, clear err, enter SCAN.
  - If modulus==0, go to FIN with err=1 and result=0.
- SCAN: one exponent bit per cycle, from idx downward.
  - If exp[idx]=1, go to SQR_REQ.
  - If the bit is 0 and idx>0, decrement idx.
  - If the bit is 0 and idx==0, e==0: result = (N==1) ? 0 : 1, go to FIN.
- SQR_REQ: mm_start=1, mm_a=mm_b=acc, then SQR_WAIT.
- SQR_WAIT: on mm_done, acc<=mm_res.
  - If exp[idx]=1, go to MUL_REQ.
  - Else if idx==0, go to FIN.
  - Else decrement idx and go to SQR_REQ.
- MUL_REQ: mm_start=1, mm_a=acc, mm_b=base, then MUL_WAIT.
- MUL_WAIT: on mm_done, acc<=mm_res.
  - If idx==0, go to FIN.
  - Else decrement idx and go to SQR_REQ.
- FIN: result<=acc (or the special value set above), done=1 for one cycle, busy=0, go to IDLE.
- Handshake count: exactly (msb+1) squares plus popcount(e) multiplies. Never more than one outstanding operation. mm_start is never asserted while waiting.
- An mm_done arriving outside a WAIT state is ignored.
- start while busy is ignored, with no side effects.
- Reset mid-operation: return to IDLE next cycle, mm_start=0, done never pulses. A late mm_done afterwards is ignored.
- Base is not pre-reduced here; the multiplier must accept operands >= N.

Decomposition:
- Shared package mod_exp_pkg: WIDTH/EXP_WIDTH defaults and the state encoding constants.
- One natural sub-module: msb_scan, the sequential bit scanner (load, step, found, zero, idx).
- The multiplier stays outside this block.

Test Plan:
- base=3, N=7, e=5, stub multiplier latency 4: result=5, err=0, 5 mm_start pulses (3 squares, 2 multiplies), done exactly once.
- base=4, N=497, e=13, random multiplier latency 1..10: result=445, 7 handshakes.
- e=0, N=7: result=1 after 32 scan cycles with zero mm_start. e=0, N=1: result=0.
- N=0, base=5, e=3: done pulses with err=1, result=0, no mm_start.
- Reset after the 2nd mm_start, then a late mm_done: outputs at reset values, no done pulse. A following run of 3^5 mod 7 gives 5.
- start re-pulsed while busy with different operands: ignored, first result (5) returned. Also check e=0x80000000, N=1000003, base=2: result matches the reference model.
